// File: rtl/debounce_pkg.sv
// Shared definitions for the switch/level debouncer.
// Holds the FSM state encoding and the default qualification length.
// No logic lives here; debounce_edge imports it.
package debounce_pkg;

  // Qualification length used when the parent does not override it.
  localparam int STABLE_COUNT_DEF = 4;

  // Two stable states plus one "checking" state for each direction.
  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHECK_HI  = 2'd1,
    STABLE_HI = 2'd2,
    CHECK_LO  = 2'd3
  } state_t;

endpackage

// File: rtl/debounce_edge.sv
// Purpose: debounce an already-synchronized level and flag its accepted edges.
// Latency: dout/rise/fall change on the edge sampling the STABLE_COUNT-th consecutive differing din.
// Backpressure: none; din is sampled every clk cycle and outputs are always valid.
//
// Ports:
//   clk   - single clock, all state on its rising edge
//   reset - synchronous, active-low
//   din   - input level, driven by the upstream sync_ff stage (sync_ff.q)
//   dout  - debounced level (registered)
//   rise  - one-cycle pulse when dout goes 0->1 (registered)
//   fall  - one-cycle pulse when dout goes 1->0 (registered)
//   busy  - high while a candidate level change is being qualified
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int STABLE_COUNT = STABLE_COUNT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CW = $clog2(STABLE_COUNT + 1);
  // Count value at which the next matching sample completes qualification.
  localparam logic [CW-1:0] LAST = CW'(STABLE_COUNT - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          dout_n, rise_n, fall_n;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= STABLE_LO;
      cnt   <= '0;
      dout  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dout  <= dout_n;
      rise  <= rise_n;
      fall  <= fall_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dout_n  = dout;
    rise_n  = 1'b0;
    fall_n  = 1'b0;

    case (state)
      STABLE_LO: begin
        if (din) begin
          state_n = CHECK_HI;
          cnt_n   = CW'(1);
        end else begin
          cnt_n   = '0;
        end
      end

      CHECK_HI: begin
        if (!din) begin
          // Glitch: fall back without touching dout.
          state_n = STABLE_LO;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n = STABLE_HI;
          dout_n  = 1'b1;
          rise_n  = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n   = cnt + 1'b1;
        end
      end

      STABLE_HI: begin
        if (!din) begin
          state_n = CHECK_LO;
          cnt_n   = CW'(1);
        end else begin
          cnt_n   = '0;
        end
      end

      CHECK_LO: begin
        if (din) begin
          state_n = STABLE_HI;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n = STABLE_LO;
          dout_n  = 1'b0;
          fall_n  = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n   = cnt + 1'b1;
        end
      end

      default: begin
        state_n = STABLE_LO;
        cnt_n   = '0;
        dout_n  = 1'b0;
      end
    endcase
  end

  // Decoded straight from the state register, so it is glitch-free and
  // cleared by reset along with the state.
  assign busy = (state == CHECK_HI) || (state == CHECK_LO);

endmodule

// File: tb/tb_debounce_edge.sv
module tb_debounce_edge;

  localparam int SC = 4;

  logic clk = 1'b0;
  logic reset;
  logic din;
  logic dout, rise, fall, busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Expected {dout, rise, fall, busy} after each edge, oldest first.
  logic [3:0] exp_q[$];
  bit         chk_cnt = 1'b0;

  // Reference model: length of the current run of samples differing from dout.
  bit m_dout = 1'b0;
  int m_run  = 0;

  debounce_edge #(.STABLE_COUNT(SC)) dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .dout  (dout),
    .rise  (rise),
    .fall  (fall),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Drive one sample and predict the outputs after the edge that takes it.
  task automatic step(input bit r, input bit d);
    bit er, ef;
    @(negedge clk);
    reset = r;
    din   = d;
    er = 1'b0;
    ef = 1'b0;
    if (!r) begin
      m_dout = 1'b0;
      m_run  = 0;
    end else if (d != m_dout) begin
      m_run++;
      if (m_run == SC) begin
        er     = d;
        ef     = !d;
        m_dout = d;
        m_run  = 0;
      end
    end else begin
      m_run = 0;
    end
    exp_q.push_back({m_dout, er, ef, (m_run > 0)});
  endtask

  task automatic hold(input bit r, input bit d, input int n);
    for (int i = 0; i < n; i++) step(r, d);
  endtask

  // Monitor: after each edge, compare DUT outputs with the oldest prediction.
  initial begin
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if ({dout, rise, fall, busy} !== e) begin
          fails++;
          $display("FAIL outputs cycle %0d: dout/rise/fall/busy got %b%b%b%b required %b",
                   cyc, dout, rise, fall, busy, e);
        end
        tests++;
        if ((rise & fall) !== 1'b0) begin
          fails++;
          $display("FAIL rise_and_fall cycle %0d: got rise=%b fall=%b required not both high",
                   cyc, rise, fall);
        end
        if (chk_cnt) begin
          tests++;
          if (int'(dut.cnt) > 1) begin
            fails++;
            $display("FAIL cnt_bound cycle %0d: got cnt=%0d required <= 1", cyc, dut.cnt);
          end
        end
      end
    end
  end

  initial begin
    bit d;
    int run_left;
    reset = 1'b0;
    din   = 1'b0;

    // Reset held low with din high: everything stays cleared.
    hold(0, 1, 2);
    // Clean rise after SC high samples, rise lasts one cycle.
    hold(1, 1, SC + 1);
    // Clean fall.
    hold(1, 0, SC + 1);
    // Short high burst is rejected.
    hold(1, 1, SC - 1);
    hold(1, 0, 2);
    // Reset mid-qualification discards the partial count.
    hold(1, 1, 2);
    step(0, 1);
    hold(1, 1, SC + 1);
    hold(1, 0, SC + 1);
    // Alternating input never qualifies.
    chk_cnt = 1'b1;
    for (int i = 0; i < 20; i++) step(1, (i % 2) == 0);
    @(negedge clk);
    chk_cnt = 1'b0;
    exp_q.delete();

    // Randomized runs of varying length with rare resets.
    d = 1'b0;
    run_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run_left == 0) begin
        d = ~d;
        run_left = $urandom_range(1, SC + 2);
      end
      run_left--;
      step(($urandom_range(0, 49) != 0), d);
    end

    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d unchecked predictions required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/debounce_edge.md
DEBOUNCE_EDGE -- requirements
Module: debounce_edge

Interface
REQ-001 SHALL have parameter STABLE_COUNT, default 4; the number of consecutive identical samples required to accept a level change; legal range 2..65535.
REQ-002 SHALL have port clk, input, 1 bit; the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit; reset is synchronous and active-low.
REQ-004 SHALL have port din, input, 1 bit; a level already synchronized to clk by the upstream sync_ff stage.
REQ-005 SHALL have port dout, output, 1 bit; the debounced level, registered.
REQ-006 SHALL have port rise, output, 1 bit; one-cycle pulse when dout goes 0->1, registered.
REQ-007 SHALL have port fall, output, 1 bit; one-cycle pulse when dout goes 1->0, registered.
REQ-008 SHALL have port busy, output, 1 bit; 1 while a candidate level change is being qualified.

Function
REQ-009 SHALL implement a four-state FSM: STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO.
REQ-010 SHALL hold a counter cnt of width $clog2(STABLE_COUNT+1) bits, counting consecutive samples of din that differ from dout.
REQ-011 In STABLE_LO, din=1 SHALL move the FSM to CHECK_HI with cnt<=1; din=0 SHALL hold the state with cnt<=0.
REQ-012 In CHECK_HI, din=0 SHALL return the FSM to STABLE_LO with cnt<=0 (glitch rejected, no pulse).
REQ-013 In CHECK_HI, din=1 with cnt==STABLE_COUNT-1 SHALL move the FSM to STABLE_HI with dout<=1, rise<=1 and cnt<=0; otherwise cnt SHALL increment.
REQ-014 STABLE_HI and CHECK_LO SHALL mirror REQ-011 to REQ-013 with din polarity inverted, dout<=0 and fall<=1.
REQ-015 Latency: dout SHALL change on the same edge that samples the STABLE_COUNT-th consecutive differing din value.
REQ-016 rise and fall SHALL each be high for exactly one cycle per accepted transition and SHALL never both be high in the same cycle.
REQ-017 busy SHALL equal 1 exactly when the FSM is in CHECK_HI or CHECK_LO.
REQ-018 cnt SHALL never exceed STABLE_COUNT-1 and SHALL never wrap.
REQ-019 A din toggle on the cycle that completes qualification SHALL NOT occur, because the completing sample is by definition a matching one; the next sample SHALL be judged against the new dout.

Reset
REQ-020 When reset=0 at a rising clk edge, the block SHALL set state<=STABLE_LO, cnt<=0, dout<=0, rise<=0, fall<=0 and busy<=0, regardless of din or current state.
REQ-021 Reset asserted mid-qualification SHALL discard the partial count; after release, qualification SHALL restart from cnt=1 on the first high sample.
REQ-022 Reset SHALL take priority over all FSM transitions on the same edge.

Structure
REQ-023 The FSM state enum SHALL be defined in a shared package, debounce_pkg.
REQ-024 debounce_pkg SHALL define the default STABLE_COUNT constant.
REQ-025 The block SHALL instantiate no sub-modules; the parent SHALL place sync_ff directly upstream, connecting sync_ff.q to din.

Verification
REQ-026 With STABLE_COUNT=4, hold reset=0 for 2 cycles with din=1 -> dout=0, rise=0, fall=0, busy=0 throughout.
REQ-027 From reset, hold din=1 for 4 edges -> busy=1 after edge 1; dout=1 and rise=1 after edge 4; rise=0 after edge 5.
REQ-028 Apply din=1 for 3 edges, then 0 -> dout stays 0, rise never asserts, busy returns to 0.
REQ-029 From dout=1, hold din=0 for 4 edges -> dout=0 and fall=1 for exactly one cycle after edge 4.
REQ-030 Apply din=1 for 2 edges, then reset=0 for 1 edge, then din=1 -> all outputs cleared; rise is reached only after 4 further high samples.
REQ-031 Drive din with alternating 1,0 for 20 cycles -> dout, rise and fall stay 0 and cnt never exceeds 1.
